// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the PIO edge-capture interrupt block: register map and widths.
package soc_system_pio_pkg;

    localparam int PIO_WIDTH  = 8;
    localparam int DEBOUNCE_W = 8;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;

endpackage

// File: rtl/pio_in_filter.sv
// One input bit: two-flop synchroniser followed by an optional debounce filter.
// Debounce present only when PIO_EDGE_IRQ_DEBOUNCE_EN is defined.
module pio_in_filter
    import soc_system_pio_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_bit,
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    input  logic [DEBOUNCE_W-1:0] threshold,
`endif
    output logic                  filt
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic filt_q, filt_d;

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic [DEBOUNCE_W-1:0] thr_eff;

    // ">=" rather than "==" so lowering the threshold mid-count still fires.
    always_comb begin
        sync1_d = in_bit;
        sync2_d = sync1_q;
        thr_eff = (threshold == '0) ? DEBOUNCE_W'(1) : threshold;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q >= thr_eff - DEBOUNCE_W'(1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        sync1_d = in_bit;
        sync2_d = sync1_q;
        filt_d  = sync2_q;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/soc_system_pio_edge_irq.sv
// Avalon-MM input port with programmable rising/falling edge capture and level irq.
// Optional per-bit debounce and DEBOUNCE register under PIO_EDGE_IRQ_DEBOUNCE_EN.
module soc_system_pio_edge_irq
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_DEFAULT = 16
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [PIO_WIDTH-1:0] in_port,
    output logic                 irq
);

    logic [PIO_WIDTH-1:0] filt;
    logic [PIO_WIDTH-1:0] prev_q, prev_d;
    logic [PIO_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [PIO_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [PIO_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [PIO_WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 irq_q, irq_d;

    logic                 wr_en;
    logic [PIO_WIDTH-1:0] wdata;
    logic [PIO_WIDTH-1:0] clear_mask;
    logic [PIO_WIDTH-1:0] rise_ev;
    logic [PIO_WIDTH-1:0] fall_ev;
    logic [PIO_WIDTH-1:0] rd_mux;
    logic [31-PIO_WIDTH:0] wdata_unused;

    assign wdata_unused = writedata[31:PIO_WIDTH];

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] debounce_q, debounce_d;
`else
    logic [DEBOUNCE_W-1:0] debounce_unused;
    assign debounce_unused = DEBOUNCE_W'(DEBOUNCE_DEFAULT);
`endif

    for (genvar i = 0; i < PIO_WIDTH; i++) begin : g_bit
        pio_in_filter u_filt (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_bit    (in_port[i]),
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
            .threshold (debounce_q),
`endif
            .filt      (filt[i])
        );
    end

    always_comb begin
        wr_en      = chipselect & ~write_n;
        wdata      = writedata[PIO_WIDTH-1:0];
        prev_d     = filt;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
        debounce_d = debounce_q;
`endif

        clear_mask = (wr_en && address == ADDR_EDGE_CAP) ? wdata : '0;
        rise_ev    = filt & ~prev_q & rise_en_q;
        fall_ev    = ~filt & prev_q & fall_en_q;
        // New edges are OR-ed in after the clear so a same-cycle set survives.
        edge_cap_d = (edge_cap_q & ~clear_mask) | rise_ev | fall_ev;

        if (wr_en) begin
            case (address)
                ADDR_RISE_EN:  rise_en_d  = wdata;
                ADDR_IRQ_MASK: irq_mask_d = wdata;
                ADDR_FALL_EN:  fall_en_d  = wdata;
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
                ADDR_DEBOUNCE: debounce_d = wdata;
`endif
                default: ;
            endcase
        end

        irq_d = |(edge_cap_d & irq_mask_d);

        case (address)
            ADDR_DATA:     rd_mux = filt;
            ADDR_RISE_EN:  rd_mux = rise_en_q;
            ADDR_IRQ_MASK: rd_mux = irq_mask_q;
            ADDR_EDGE_CAP: rd_mux = edge_cap_q;
            ADDR_FALL_EN:  rd_mux = fall_en_q;
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
            ADDR_DEBOUNCE: rd_mux = debounce_q;
`else
            ADDR_DEBOUNCE: rd_mux = '0;
`endif
            default:       rd_mux = '0;
        endcase
        readdata_d = {{(32-PIO_WIDTH){1'b0}}, rd_mux};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounce_q <= DEBOUNCE_W'(DEBOUNCE_DEFAULT);
        end else begin
            debounce_q <= debounce_d;
        end
    end
`endif

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_pio_edge_irq.sv
// Bench for soc_system_pio_edge_irq: register table, hand-written edge/timing sequences,
// and a randomized phase checked against a cycle-history reference model.
module tb_soc_system_pio_edge_irq;

    localparam int DB_DEF = 16;
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    localparam bit HAS_DB = 1'b1;
`else
    localparam bit HAS_DB = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    soc_system_pio_edge_irq #(.DEBOUNCE_DEFAULT(DB_DEF)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        idle_bus();
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    function automatic logic [7:0] reset_val(input logic [2:0] a);
        return (a == 3'd5 && HAS_DB) ? 8'(DB_DEF) : 8'h00;
    endfunction

    // reference model: input samples per edge plus shadow registers
    logic [7:0] in_h[$];
    logic [7:0] m_rise, m_fall, m_mask, m_cap;
    logic [7:0] cur_in;

    task automatic model_reset();
        in_h   = '{8'h00, 8'h00, 8'h00, 8'h00};
        m_rise = '0;
        m_fall = '0;
        m_mask = '0;
        m_cap  = '0;
    endtask

    // One bus cycle; a pin sample becomes visible to edge detection three edges later.
    task automatic do_cycle(input logic [2:0] a, input bit w, input logic [7:0] wd, input logic [7:0] inp);
        logic [7:0] f, p, clr, rd_exp;
        int sel;
        address = a;
        in_port = inp;
        if (w) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            writedata  = {8'($urandom), 8'($urandom), 8'($urandom), wd};
        end else begin
            sel = $urandom_range(0, 2);
            chipselect = (sel == 2);
            write_n    = (sel != 0);
            writedata  = $urandom;
        end
        in_h.push_back(inp);
        f = in_h[in_h.size()-4];
        p = in_h[in_h.size()-5];
        case (a)
            3'd0:    rd_exp = f;
            3'd1:    rd_exp = m_rise;
            3'd2:    rd_exp = m_mask;
            3'd3:    rd_exp = m_cap;
            3'd4:    rd_exp = m_fall;
            3'd5:    rd_exp = HAS_DB ? 8'd1 : 8'd0;
            default: rd_exp = 8'h00;
        endcase
        clr   = (w && a == 3'd3) ? wd : 8'h00;
        m_cap = (m_cap & ~clr) | (f & ~p & m_rise) | (~f & p & m_fall);
        if (w) begin
            if (a == 3'd1) m_rise = wd;
            if (a == 3'd2) m_mask = wd;
            if (a == 3'd4) m_fall = wd;
        end
        tick();
        idle_bus();
        chk("rand_readdata", readdata, {24'h0, rd_exp});
        chk("rand_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
    endtask

    function automatic logic [7:0] next_in();
        if ($urandom_range(0, 2) == 0) cur_in = 8'($urandom);
        return cur_in;
    endfunction

    typedef struct {
        string       name;
        logic [2:0]  addr;
        bit          do_wr;
        logic [31:0] wdata;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [31:0] got;
        logic [2:0]  wa;

        vt[0]  = '{"rise_en_rw",    3'd1, 1'b1, 32'hFFFF_FFA5, 8'hA5};
        vt[1]  = '{"irq_mask_rw",   3'd2, 1'b1, 32'h0000_003C, 8'h3C};
        vt[2]  = '{"fall_en_rw",    3'd4, 1'b1, 32'h1234_5681, 8'h81};
        vt[3]  = '{"data_ro",       3'd0, 1'b1, 32'h0000_00FF, 8'h00};
        vt[4]  = '{"edge_cap_idle", 3'd3, 1'b0, 32'h0,         8'h00};
        vt[5]  = '{"addr6_ignored", 3'd6, 1'b1, 32'h0000_00FF, 8'h00};
        vt[6]  = '{"addr7_ignored", 3'd7, 1'b1, 32'h0000_00FF, 8'h00};
        vt[7]  = '{"rise_en_keep",  3'd1, 1'b0, 32'h0,         8'hA5};
        vt[8]  = '{"irq_mask_keep", 3'd2, 1'b0, 32'h0,         8'h3C};
        vt[9]  = '{"fall_en_keep",  3'd4, 1'b0, 32'h0,         8'h81};
        vt[10] = '{"debounce_rw7",  3'd5, 1'b1, 32'h0000_0007, HAS_DB ? 8'h07 : 8'h00};
        vt[11] = '{"debounce_rw1",  3'd5, 1'b1, 32'h0000_0001, HAS_DB ? 8'h01 : 8'h00};

        reset_n = 1'b0;
        address = '0;
        in_port = '0;
        cur_in  = '0;
        idle_bus();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), got);
            chk($sformatf("reset_reg%0d", a), got, {24'h0, reset_val(3'(a))});
        end

        for (int i = 0; i < 12; i++) begin
            if (vt[i].do_wr) wr(vt[i].addr, vt[i].wdata);
            rd(vt[i].addr, got);
            chk(vt[i].name, got, {24'h0, vt[i].exp});
        end
        wr(3'd1, 0);
        wr(3'd2, 0);
        wr(3'd4, 0);

        // write strobe needs chipselect
        address = 3'd1; chipselect = 1'b0; write_n = 1'b0; writedata = 32'hFF;
        tick();
        idle_bus();
        rd(3'd1, got);
        chk("cs_qualifies_write", got, 32'h0);

        // rising edge on bit 0: capture and irq three edges after the sample
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        tick();
        tick();
        tick();
        chk("rise_irq_n2", {31'h0, irq}, 32'h0);
        tick();
        chk("rise_irq_n3", {31'h0, irq}, 32'h1);
        rd(3'd3, got);
        chk("rise_cap", got, 32'h01);
        rd(3'd0, got);
        chk("rise_data", got, 32'h01);
        wr(3'd3, 32'h01);
        chk("w1c_irq", {31'h0, irq}, 32'h0);
        rd(3'd3, got);
        chk("w1c_cap", got, 32'h0);

        // masked falling edge on bit 7
        wr(3'd1, 0);
        wr(3'd2, 0);
        in_port = 8'h81;
        repeat (6) tick();
        wr(3'd4, 32'h80);
        in_port = 8'h01;
        repeat (6) tick();
        chk("fall_masked_irq", {31'h0, irq}, 32'h0);
        rd(3'd3, got);
        chk("fall_cap", got, 32'h80);
        wr(3'd2, 32'h80);
        chk("unmask_irq", {31'h0, irq}, 32'h1);
        wr(3'd2, 0);
        chk("remask_irq", {31'h0, irq}, 32'h0);
        rd(3'd3, got);
        chk("mask_keeps_cap", got, 32'h80);
        wr(3'd3, 32'hFF);
        wr(3'd4, 0);

        // edge capture and W1C of the same bit on the same edge
        wr(3'd1, 32'h04);
        in_port = 8'h05;
        tick();
        tick();
        tick();
        wr(3'd3, 32'h04);
        rd(3'd3, got);
        chk("set_beats_clear", got, 32'h04);
        wr(3'd3, 32'h04);
        rd(3'd3, got);
        chk("clear_after_set", got, 32'h0);

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
        // T=4: 3-cycle glitch rejected, longer pulse passes at N+5
        wr(3'd5, 32'h04);
        wr(3'd1, 32'h02);
        in_port = 8'h07;
        repeat (3) tick();
        in_port = 8'h05;
        repeat (8) tick();
        rd(3'd0, got);
        chk("glitch_data", got, 32'h05);
        rd(3'd3, got);
        chk("glitch_cap", got, 32'h0);
        address = 3'd0;
        in_port = 8'h07;
        tick();
        repeat (5) tick();
        chk("db_data_n5_minus", readdata, 32'h05);
        tick();
        chk("db_data_n5", readdata, 32'h07);
        rd(3'd3, got);
        chk("db_cap", got, 32'h02);
`endif

        // asynchronous reset mid-traffic
        wr(3'd1, 32'h5A);
        address = 3'd1;
        tick();
        chk("pre_reset_read", readdata, 32'h5A);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", readdata, 32'h0);
        chk("async_reset_irq", {31'h0, irq}, 32'h0);
        in_port = 8'h00;
        cur_in  = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), got);
            chk($sformatf("post_reset_reg%0d", a), got, {24'h0, reset_val(3'(a))});
        end

        // randomized traffic against the model
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
        wr(3'd5, 32'h01);
`endif
        model_reset();
        for (int c = 0; c < 8; c++) begin
            do_cycle(3'd1, 1'b1, 8'($urandom), next_in());
            do_cycle(3'd4, 1'b1, 8'($urandom), next_in());
            do_cycle(3'd2, 1'b1, 8'($urandom), next_in());
            for (int j = 0; j < 30; j++) begin
                if ($urandom_range(0, 7) == 0) begin
                    wa = 3'($urandom_range(0, 7));
                    if (wa == 3'd5) wa = 3'd3;
                    do_cycle(wa, 1'b1, 8'($urandom), next_in());
                end else begin
                    do_cycle(3'($urandom_range(0, 7)), 1'b0, 8'h00, next_in());
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/soc_system_pio_edge_irq.md
# soc_system_pio_edge_irq

Avalon-MM input-port stage paired with the HPS-side bidirectional PIO: it consumes the 8 pad-side bits the PIO exposes as inputs (bidir_port lines with direction cleared), resynchronises and optionally debounces them, captures programmable rising/falling edges into a sticky register, and raises a level interrupt to the HPS. It sits between the board pins and the lightweight HPS-to-FPGA bridge, alongside the existing PIO in soc_system.

## Interface
- DEBOUNCE_DEFAULT, 16: reset value of the debounce threshold register (1..255).
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset; all flops clear (or load stated reset value) immediately.
- address  in  3  Avalon-MM word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; only [7:0] used.
- readdata  out  32  registered read data; [31:8] always 0; reset 0.
- in_port  in  8  asynchronous pin inputs.
- irq  out  1  level interrupt, high while any unmasked capture bit is set; reset 0.

## Operation
- Register map (8-bit, zero-extended on read):
  - 0 DATA, RO: filtered input value. Reset 0.
  - 1 RISE_EN, RW: per-bit rising-edge capture enable. Reset 0.
  - 2 IRQ_MASK, RW: per-bit interrupt enable. Reset 0.
  - 3 EDGE_CAP, read / write-1-to-clear. Reset 0.
  - 4 FALL_EN, RW: per-bit falling-edge capture enable. Reset 0.
  - 5 DEBOUNCE, RW: threshold T (only with macro; otherwise reads 0, writes ignored). Reset DEBOUNCE_DEFAULT.
  - 6, 7: read 0, writes ignored.
- Write strobe = chipselect & ~write_n; no wait states, no read side effects.
- Input path per bit: two-flop synchroniser (sync1, sync2, reset 0) -> filter -> filt (reset 0) -> prev (reset 0).
- Edge: rise = filt & ~prev & RISE_EN; fall = ~filt & prev & FALL_EN.
- EDGE_CAP next = (EDGE_CAP & ~clear_mask) | rise | fall; clear_mask = writedata[7:0] on write to address 3, else 0. Set wins over clear on the same bit in the same cycle.
- irq = |(EDGE_CAP & IRQ_MASK), driven only from flops (glitch-free). Masking does not clear EDGE_CAP; unmasking a set bit raises irq.
- Enabling RISE_EN/FALL_EN while a level is steady captures nothing; only transitions of filt count.

## Timing
- readdata registered: valid the cycle after the address is presented (chipselect not required for reads, matching the PIO).
- Read of a register written in cycle N returns the new value if the read address is presented in cycle N+1 or later.
- Filter without debounce: filt <= sync2 every cycle. in_port change sampled at edge N -> sync2 at N+1 -> filt at N+2 -> EDGE_CAP/DATA at N+3 -> irq at N+3.
- Filter with debounce: per-bit 8-bit counter; increments each cycle sync2 != filt; cleared when sync2 == filt. When sync2 != filt and counter == T-1, filt <= sync2 and counter clears. T = 0 behaves as T = 1. filt updates at N+1+T; pulses shorter than T cycles at sync2 are rejected.
- Writing DEBOUNCE mid-count: new T applies next cycle; a counter already >= new T-1 fires on the next differing cycle.
- Reset mid-operation: all state clears asynchronously; after release prev = filt = 0, so a high input produces a rising edge (captured only if RISE_EN is set).

## Configuration
- PIO_EDGE_IRQ_DEBOUNCE_EN defined: per-bit debounce counters and DEBOUNCE register (address 5) present.
- Undefined: counters and register removed; filt is a plain register of sync2; address 5 reads 0; DEBOUNCE_DEFAULT unused.

## Structure
- Package soc_system_pio_pkg: address constants (ADDR_DATA..ADDR_DEBOUNCE), PIO_WIDTH = 8, DEBOUNCE_W = 8.
- Sub-module pio_in_filter: one bit of synchroniser + debounce (threshold input, filt output), instantiated 8 times via generate. Top level holds registers, edge logic, read mux, irq.

## Test plan
- Reset: assert reset_n low mid-traffic -> readdata, irq, all registers 0; DEBOUNCE reads DEBOUNCE_DEFAULT (macro on).
- Rising edge: RISE_EN=0x01, IRQ_MASK=0x01, in_port[0] 0->1 -> EDGE_CAP=0x01 and irq=1 three cycles later (no debounce); write 0x01 to address 3 -> irq=0 next cycle.
- Falling edge masked: FALL_EN=0x80, IRQ_MASK=0, in_port[7] 1->0 -> EDGE_CAP=0x80, irq stays 0; then IRQ_MASK=0x80 -> irq=1.
- Set vs clear collision: edge on bit 2 in the same cycle as W1C write 0x04 -> EDGE_CAP[2] remains 1.
- Debounce (macro on): T=4, 3-cycle high glitch -> DATA stays 0, no capture; 6-cycle high -> DATA=1 at N+5.
- Unused addresses: write 0xFF to addresses 6 and 7 -> no register changes; reads return 0.
